nn_sequencer: RTL and testbench
===============================

Name: nn_sequencer

Overview:
- Initiator-side controller for the 10-lane neural network datapath. It drives the datapath's start, hidden, ld1, ld2 and state inputs and consumes its ready and test_out outputs.
- Runs a batch of NUM_SAMPLES test vectors in three phases each: hidden group A (state 00), hidden group B (state 01), output layer (state 10).
- Presents a sample index to the external test-data memory and returns one class result per sample.

Parameters:
- NUM_SAMPLES, 16, samples per batch (1..2^IDX_W).
- IDX_W, 8, width of sample index.
- SETTLE_CYC, 1, idle cycles after sample_idx changes before first start (memory read latency, 0..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- go  in  1  begin batch; sampled only in IDLE
- abort  in  1  cancel batch; returns to IDLE next cycle
- ann_ready  in  1  datapath ready (AND of all lanes)
- ann_test_out  in  8  datapath class output
- ann_start  out  1  one-cycle start pulse to datapath
- ann_hidden  out  1  hidden-layer activation select
- ann_ld1  out  1  load hidden group A registers
- ann_ld2  out  1  load hidden group B registers
- ann_state  out  2  layer select: 00 group A, 01 group B, 10 output
- sample_idx  out  IDX_W  test-data memory address
- busy  out  1  high in every state except IDLE
- result_valid  out  1  one-cycle pulse, class result available
- result_class  out  8  captured class, held until next capture
- result_idx  out  IDX_W  index of captured sample
- done  out  1  one-cycle pulse after last sample captured

Behaviour:
- Reset: all outputs 0; FSM to IDLE; sample_idx=0; result_class=0.
- States: IDLE, SETTLE, A_START, A_WAIT, A_LOAD, B_START, B_WAIT, B_LOAD, O_START, O_WAIT, O_CAP.
- IDLE + go: sample_idx<=0, settle counter<=SETTLE_CYC, go to SETTLE. If SETTLE_CYC=0, go directly to A_START.
- SETTLE: decrement the counter each cycle; leave for A_START when the counter reaches 0.
- x_START: ann_start=1 for exactly one cycle, then x_WAIT.
- x_WAIT:
  - ann_ready is ignored in the first WAIT cycle, because the lanes need one cycle to drop ready.
  - From the second WAIT cycle on, ann_ready=1 advances to x_LOAD or O_CAP.
  - No timeout.
- A_LOAD: ann_ld1=1 one cycle, then B_START.
- B_LOAD: ann_ld2=1 one cycle, then O_START.
- O_CAP:
  - result_class<=ann_test_out, result_idx<=sample_idx, result_valid=1 for one cycle.
  - If sample_idx==NUM_SAMPLES-1: done=1 the same cycle, then IDLE.
  - Otherwise sample_idx<=sample_idx+1 and go to SETTLE (or A_START if SETTLE_CYC=0).
- ann_state: 00 in IDLE, SETTLE and A_*; 01 in B_*; 10 in O_*. It is registered and stable throughout each phase, including the LOAD/CAP cycle, so the datapath mux selects the correct results.
- ann_hidden: 1 in A_* and B_*; 0 otherwise.
- Minimum per-sample latency: SETTLE_CYC + 3 × (1 start + WAIT + 1) cycles.
- abort:
  - Overrides all transitions; next state IDLE.
  - No result_valid or done is emitted.
  - sample_idx is held; it resets on the next go.
  - abort together with go in IDLE means abort wins and the FSM stays in IDLE.
- go while busy is ignored.
- rst mid-batch: identical to the reset values above on the next edge.
- sample_idx does not wrap past NUM_SAMPLES-1. With NUM_SAMPLES=2^IDX_W, the last index is all ones and the batch ends there.

Optional Feature:
- Macro: NN_SEQ_ACCURACY_EN.
- Enabled:
  - Adds input label (8) and outputs correct_cnt (IDX_W+1) and mismatch (1).
  - In O_CAP, if ann_test_out==label, correct_cnt increments; otherwise mismatch pulses for one cycle.
  - correct_cnt clears on go in IDLE and on rst, and holds after done.
- Disabled: those ports and the counter do not exist; all other behaviour is identical.

Decomposition:
- Package nn_seq_pkg: FSM state enum; layer-select constants LAYER_A=2'b00, LAYER_B=2'b01, LAYER_OUT=2'b10.
- One natural sub-module: nn_seq_phase, a start/wait/load handshake unit instanced per phase or time-shared by the FSM. Flat implementation is also acceptable.

Test Plan:
- NUM_SAMPLES=1, SETTLE_CYC=1; ann_ready model rises 5 cycles after each start; test_out=8'd7.
  - Required: exactly 3 start pulses with ann_state 00, 01, 10.
  - Required: ld1 and ld2 each pulse once, inside state 00 and 01 respectively.
  - Required: result_valid with result_class=7 and result_idx=0, coincident with done.
- Stale ready: hold ann_ready=1 continuously.
  - Required: each phase still spends ≥2 WAIT cycles.
  - Required: no phase is skipped; order is start→ld1→start→ld2→start→capture.
- NUM_SAMPLES=4, SETTLE_CYC=3, test_out=index+2.
  - Required: sample_idx steps 0..3, with 3 idle cycles after each change.
  - Required: results 2,3,4,5 in order; done once, on idx 3.
- Assert abort during B_WAIT of sample 2.
  - Required: IDLE next cycle; busy=0; no result_valid or done; sample_idx held at 2.
  - Then go: restart at idx 0.
- Reset and go handling:
  - rst asserted during O_WAIT: all outputs 0 on the next cycle.
  - go during busy: ignored, no second batch.
  - go+abort together in IDLE: stays in IDLE.
- NN_SEQ_ACCURACY_EN, 4 samples with labels 2,9,4,5 against outputs 2,3,4,5.
  - Required: correct_cnt=3; one mismatch pulse, at idx 1.

Source files
------------

// File: rtl/nn_seq_pkg.sv
// Shared types for the neural-network sequencer: FSM states and layer-select codes.
package nn_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETTLE,
        S_A_START,
        S_A_WAIT,
        S_A_LOAD,
        S_B_START,
        S_B_WAIT,
        S_B_LOAD,
        S_O_START,
        S_O_WAIT,
        S_O_CAP
    } seq_state_e;

    localparam logic [1:0] LAYER_A   = 2'b00;
    localparam logic [1:0] LAYER_B   = 2'b01;
    localparam logic [1:0] LAYER_OUT = 2'b10;

    // Layer the datapath mux must select while the FSM sits in a given state.
    function automatic logic [1:0] layer_of(seq_state_e s);
        case (s)
            S_B_START, S_B_WAIT, S_B_LOAD: return LAYER_B;
            S_O_START, S_O_WAIT, S_O_CAP:  return LAYER_OUT;
            default:                       return LAYER_A;
        endcase
    endfunction

endpackage

// File: rtl/nn_sequencer_if.sv
// Control/status bundle between the sequencer (master) and the 10-lane datapath (slave).
interface nn_sequencer_if;
    logic       ann_start;
    logic       ann_hidden;
    logic       ann_ld1;
    logic       ann_ld2;
    logic [1:0] ann_state;
    logic       ann_ready;
    logic [7:0] ann_test_out;

    modport master (
        output ann_start, ann_hidden, ann_ld1, ann_ld2, ann_state,
        input  ann_ready, ann_test_out
    );

    modport slave (
        input  ann_start, ann_hidden, ann_ld1, ann_ld2, ann_state,
        output ann_ready, ann_test_out
    );
endinterface

// File: rtl/nn_seq_phase.sv
// Start/wait handshake unit, time-shared by all three layer phases of the sequencer.
module nn_seq_phase (
    input  logic clk,
    input  logic rst,
    input  logic start_state_i,
    input  logic wait_state_i,
    input  logic ready_i,
    output logic start_o,
    output logic advance_o
);

    logic first_wait_q;

    // Ready still reflects the previous phase in the cycle right after start.
    always_ff @(posedge clk) begin
        if (rst) first_wait_q <= 1'b0;
        else     first_wait_q <= start_state_i;
    end

    assign start_o   = start_state_i;
    assign advance_o = wait_state_i && !first_wait_q && ready_i;

endmodule

// File: rtl/nn_sequencer.sv
// Batch sequencer for the 10-lane neural-network datapath: three phases per sample.
// Optional per-batch accuracy counter enabled by defining NN_SEQ_ACCURACY_EN.
module nn_sequencer
    import nn_seq_pkg::*;
#(
    parameter int NUM_SAMPLES = 16,
    parameter int IDX_W       = 8,
    parameter int SETTLE_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             abort,
    nn_sequencer_if.master   ann,
    output logic [IDX_W-1:0] sample_idx,
    output logic             busy,
    output logic             result_valid,
    output logic [7:0]       result_class,
    output logic [IDX_W-1:0] result_idx,
    output logic             done
`ifdef NN_SEQ_ACCURACY_EN
    ,
    input  logic [7:0]       label,
    output logic [IDX_W:0]   correct_cnt,
    output logic             mismatch
`endif
);

    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYC);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_SAMPLES - 1);
    localparam seq_state_e       FIRST_STATE = (SETTLE_CYC == 0) ? S_A_START : S_SETTLE;

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       settle_q, settle_d;
    logic [1:0]       layer_q;
    logic [7:0]       class_q;
    logic [IDX_W-1:0] ridx_q;

    logic go_accept, cap, last, phase_start, phase_adv;

    assign go_accept = (state_q == S_IDLE) && go && !abort;
    assign cap       = (state_q == S_O_CAP) && !abort;
    assign last      = (idx_q == LAST_IDX);

    nn_seq_phase u_phase (
        .clk           (clk),
        .rst           (rst),
        .start_state_i (state_q inside {S_A_START, S_B_START, S_O_START}),
        .wait_state_i  (state_q inside {S_A_WAIT, S_B_WAIT, S_O_WAIT}),
        .ready_i       (ann.ann_ready),
        .start_o       (phase_start),
        .advance_o     (phase_adv)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        case (state_q)
            S_IDLE: if (go_accept) begin
                idx_d    = '0;
                settle_d = SETTLE_INIT;
                state_d  = FIRST_STATE;
            end
            S_SETTLE: begin
                settle_d = settle_q - 4'd1;
                if (settle_q <= 4'd1) state_d = S_A_START;
            end
            S_A_START: state_d = S_A_WAIT;
            S_A_WAIT:  if (phase_adv) state_d = S_A_LOAD;
            S_A_LOAD:  state_d = S_B_START;
            S_B_START: state_d = S_B_WAIT;
            S_B_WAIT:  if (phase_adv) state_d = S_B_LOAD;
            S_B_LOAD:  state_d = S_O_START;
            S_O_START: state_d = S_O_WAIT;
            S_O_WAIT:  if (phase_adv) state_d = S_O_CAP;
            S_O_CAP: if (cap) begin
                if (last) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                    settle_d = SETTLE_INIT;
                    state_d  = FIRST_STATE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state, so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            layer_q  <= LAYER_A;
            class_q  <= '0;
            ridx_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            layer_q  <= layer_of(state_d);
            if (cap) begin
                class_q <= ann.ann_test_out;
                ridx_q  <= idx_q;
            end
        end
    end

    assign ann.ann_start  = phase_start;
    assign ann.ann_hidden = state_q inside {S_A_START, S_A_WAIT, S_A_LOAD,
                                            S_B_START, S_B_WAIT, S_B_LOAD};
    assign ann.ann_ld1    = (state_q == S_A_LOAD);
    assign ann.ann_ld2    = (state_q == S_B_LOAD);
    assign ann.ann_state  = layer_q;

    assign sample_idx   = idx_q;
    assign busy         = (state_q != S_IDLE);
    assign result_valid = cap;
    assign result_class = class_q;
    assign result_idx   = ridx_q;
    assign done         = cap && last;

`ifdef NN_SEQ_ACCURACY_EN
    logic [IDX_W:0] correct_q;
    logic           hit;

    assign hit = (ann.ann_test_out == label);

    always_ff @(posedge clk) begin
        if (rst)              correct_q <= '0;
        else if (go_accept)   correct_q <= '0;
        else if (cap && hit)  correct_q <= correct_q + (IDX_W+1)'(1);
    end

    assign correct_cnt = correct_q;
    assign mismatch    = cap && !hit;
`endif

endmodule

// File: tb/tb_nn_sequencer.sv
// Directed bench for nn_sequencer: a 1-sample and a 4-sample instance driven by a
// simple datapath model; accuracy checks compiled in when NN_SEQ_ACCURACY_EN is defined.
module tb_nn_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic go0 = 1'b0, abort0 = 1'b0, stale0 = 1'b0;
    logic go1 = 1'b0, abort1 = 1'b0;

    logic [7:0] idx0, class0, ridx0, idx1, class1, ridx1;
    logic       busy0, rv0, done0, busy1, rv1, done1;

    nn_sequencer_if ifc0 ();
    nn_sequencer_if ifc1 ();

`ifdef NN_SEQ_ACCURACY_EN
    logic [8:0] cc0, cc1;
    logic       mm0, mm1;
    logic [7:0] label1;
    always_comb begin
        case (idx1[1:0])
            2'd0:    label1 = 8'd2;
            2'd1:    label1 = 8'd9;
            2'd2:    label1 = 8'd4;
            default: label1 = 8'd5;
        endcase
    end
`endif

    nn_sequencer #(.NUM_SAMPLES(1), .IDX_W(8), .SETTLE_CYC(1)) u_dut0 (
        .clk(clk), .rst(rst), .go(go0), .abort(abort0), .ann(ifc0),
        .sample_idx(idx0), .busy(busy0), .result_valid(rv0),
        .result_class(class0), .result_idx(ridx0), .done(done0)
`ifdef NN_SEQ_ACCURACY_EN
        , .label(8'd7), .correct_cnt(cc0), .mismatch(mm0)
`endif
    );

    nn_sequencer #(.NUM_SAMPLES(4), .IDX_W(8), .SETTLE_CYC(3)) u_dut1 (
        .clk(clk), .rst(rst), .go(go1), .abort(abort1), .ann(ifc1),
        .sample_idx(idx1), .busy(busy1), .result_valid(rv1),
        .result_class(class1), .result_idx(ridx1), .done(done1)
`ifdef NN_SEQ_ACCURACY_EN
        , .label(label1), .correct_cnt(cc1), .mismatch(mm1)
`endif
    );

    // Datapath model: ready drops on start and rises 5 cycles after it.
    logic       rdy0_q, rdy1_q;
    logic [2:0] rc0_q, rc1_q;
    always @(posedge clk) begin
        if (rst) begin
            rdy0_q <= 1'b1; rc0_q <= 3'd0;
            rdy1_q <= 1'b1; rc1_q <= 3'd0;
        end else begin
            if (ifc0.ann_start) begin
                rdy0_q <= 1'b0; rc0_q <= 3'd4;
            end else if (rc0_q != 3'd0) begin
                rc0_q <= rc0_q - 3'd1;
                if (rc0_q == 3'd1) rdy0_q <= 1'b1;
            end
            if (ifc1.ann_start) begin
                rdy1_q <= 1'b0; rc1_q <= 3'd4;
            end else if (rc1_q != 3'd0) begin
                rc1_q <= rc1_q - 3'd1;
                if (rc1_q == 3'd1) rdy1_q <= 1'b1;
            end
        end
    end
    assign ifc0.ann_ready    = stale0 | rdy0_q;
    assign ifc0.ann_test_out = 8'd7;
    assign ifc1.ann_ready    = rdy1_q;
    assign ifc1.ann_test_out = idx1 + 8'd2;

    // Monitor for instance 0: event codes {kind, layer}, start-to-load gaps, busy cycles.
    logic [7:0] ev0 [$];
    int         gap0 [$];
    int         g0 = 0;
    int         busy_cyc0 = 0;
    always @(negedge clk) begin
        if (ifc0.ann_start) begin
            ev0.push_back({4'h1, 2'b00, ifc0.ann_state});
            g0 = 0;
        end else begin
            g0++;
            if (ifc0.ann_ld1 || ifc0.ann_ld2 || rv0) gap0.push_back(g0);
        end
        if (ifc0.ann_ld1) ev0.push_back({4'h2, 2'b00, ifc0.ann_state});
        if (ifc0.ann_ld2) ev0.push_back({4'h3, 2'b00, ifc0.ann_state});
        if (rv0)          ev0.push_back({4'h4, 3'b000, done0});
        if (busy0) busy_cyc0++;
    end

    // Monitor for instance 1: captures, settle lengths, index changes, mismatches.
    int         cap1_cls [$], cap1_idx [$], cap1_done [$];
    int         settle1 [$], chg1 [$], mmidx1 [$];
    int         sc1 = 0;
    bit         sc1_on = 1'b0, rv1_seen = 1'b0;
    logic [7:0] prev_idx1 = 8'd0;
    logic       prev_busy1 = 1'b0;
    always @(negedge clk) begin
        if (rv1_seen) begin
            cap1_cls.push_back(int'(class1));
            cap1_idx.push_back(int'(ridx1));
        end
        rv1_seen = rv1;
        if (rv1) cap1_done.push_back(int'(done1));
        if (busy1 && idx1 != prev_idx1) chg1.push_back(int'(idx1));
        if (busy1 && (!prev_busy1 || idx1 != prev_idx1)) begin
            sc1 = 1; sc1_on = 1'b1;
        end else if (sc1_on) begin
            if (ifc1.ann_start) begin
                settle1.push_back(sc1); sc1_on = 1'b0;
            end else begin
                sc1++;
            end
        end
`ifdef NN_SEQ_ACCURACY_EN
        if (mm1) mmidx1.push_back(int'(idx1));
`endif
        prev_busy1 = busy1;
        prev_idx1  = idx1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_idle0(input int budget, input string tag);
        int n = 0;
        while (busy0 && n < budget) begin step(1); n++; end
        check({tag, "_idle_timeout"}, 64'(busy0), 64'd0);
    endtask

    task automatic wait_idle1(input int budget, input string tag);
        int n = 0;
        while (busy1 && n < budget) begin step(1); n++; end
        check({tag, "_idle_timeout"}, 64'(busy1), 64'd0);
    endtask

    logic [7:0] exp_ev [6];
    int b_ev, b_gap, b_busy, b_cap, b_done, b_set, b_chg, b_mm, n_wait, dsum;
    bit found;

    initial begin
        exp_ev = '{8'h10, 8'h20, 8'h11, 8'h31, 8'h12, 8'h41};

        // Reset values
        step(3);
        check("reset_outs0", 64'({busy0, ifc0.ann_start, ifc0.ann_hidden, ifc0.ann_ld1, ifc0.ann_ld2,
                                  ifc0.ann_state, idx0, rv0, class0, ridx0, done0}), 64'd0);
        check("reset_outs1", 64'({busy1, ifc1.ann_start, ifc1.ann_hidden, ifc1.ann_ld1, ifc1.ann_ld2,
                                  ifc1.ann_state, idx1, rv1, class1, ridx1, done1}), 64'd0);
        rst = 1'b0;
        step(1);

        // Single sample, ready rising 5 cycles after each start
        b_ev = ev0.size(); b_gap = gap0.size(); b_busy = busy_cyc0;
        go0 = 1'b1; step(1); go0 = 1'b0;
        wait_idle0(200, "t1");
        check("t1_event_count", 64'(ev0.size() - b_ev), 64'd6);
        for (int k = 0; k < 6; k++) check($sformatf("t1_event%0d", k), 64'(ev0[b_ev + k]), 64'(exp_ev[k]));
        for (int k = 0; k < 3; k++) check($sformatf("t1_gap%0d", k), 64'(gap0[b_gap + k]), 64'd6);
        check("t1_busy_cycles", 64'(busy_cyc0 - b_busy), 64'd22);
        check("t1_result_class", 64'(class0), 64'd7);
        check("t1_result_idx", 64'(ridx0), 64'd0);
`ifdef NN_SEQ_ACCURACY_EN
        check("t1_correct_cnt", 64'(cc0), 64'd1);
`endif

        // Stale ready held high: each phase still takes two WAIT cycles
        stale0 = 1'b1;
        b_ev = ev0.size(); b_gap = gap0.size(); b_busy = busy_cyc0;
        go0 = 1'b1; step(1); go0 = 1'b0;
        wait_idle0(200, "t2");
        check("t2_event_count", 64'(ev0.size() - b_ev), 64'd6);
        for (int k = 0; k < 6; k++) check($sformatf("t2_event%0d", k), 64'(ev0[b_ev + k]), 64'(exp_ev[k]));
        for (int k = 0; k < 3; k++) check($sformatf("t2_gap%0d", k), 64'(gap0[b_gap + k]), 64'd3);
        check("t2_busy_cycles", 64'(busy_cyc0 - b_busy), 64'd13);
        stale0 = 1'b0;

        // Four samples, three settle cycles, test_out = index + 2
        b_cap = cap1_cls.size(); b_done = cap1_done.size(); b_set = settle1.size();
        b_chg = chg1.size(); b_mm = mmidx1.size();
        go1 = 1'b1; step(1); go1 = 1'b0;
        wait_idle1(400, "t3");
        check("t3_cap_count", 64'(cap1_cls.size() - b_cap), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_class%0d", k), 64'(cap1_cls[b_cap + k]), 64'(k + 2));
            check($sformatf("t3_idx%0d", k), 64'(cap1_idx[b_cap + k]), 64'(k));
            check($sformatf("t3_done%0d", k), 64'(cap1_done[b_done + k]), (k == 3) ? 64'd1 : 64'd0);
            check($sformatf("t3_settle%0d", k), 64'(settle1[b_set + k]), 64'd3);
        end
        check("t3_idx_changes", 64'(chg1.size() - b_chg), 64'd3);
        for (int k = 0; k < 3; k++) check($sformatf("t3_idx_step%0d", k), 64'(chg1[b_chg + k]), 64'(k + 1));
`ifdef NN_SEQ_ACCURACY_EN
        check("t3_correct_cnt", 64'(cc1), 64'd3);
        check("t3_mismatch_count", 64'(mmidx1.size() - b_mm), 64'd1);
        check("t3_mismatch_idx", 64'(mmidx1[b_mm]), 64'd1);
`endif

        // Abort during B_WAIT of sample 2
        b_cap = cap1_cls.size(); b_done = cap1_done.size();
        go1 = 1'b1; step(1); go1 = 1'b0;
        found = 1'b0; n_wait = 0;
        while (!found && n_wait < 400) begin
            if (busy1 && idx1 == 8'd2 && ifc1.ann_state == 2'b01 && !ifc1.ann_start && !ifc1.ann_ld2)
                found = 1'b1;
            else begin step(1); n_wait++; end
        end
        check("t4_reach_b_wait", 64'(found), 64'd1);
        abort1 = 1'b1; step(1); abort1 = 1'b0;
        check("t4_busy_after_abort", 64'(busy1), 64'd0);
        check("t4_state_after_abort", 64'(ifc1.ann_state), 64'd0);
        check("t4_idx_held", 64'(idx1), 64'd2);
        step(3);
        check("t4_still_idle", 64'(busy1), 64'd0);
        check("t4_idx_still_held", 64'(idx1), 64'd2);
        check("t4_cap_count", 64'(cap1_cls.size() - b_cap), 64'd2);
        dsum = 0;
        for (int k = b_done; k < cap1_done.size(); k++) dsum += cap1_done[k];
        check("t4_no_done", 64'(dsum), 64'd0);
        go1 = 1'b1; step(1); go1 = 1'b0;
        check("t4_restart_busy", 64'(busy1), 64'd1);
        check("t4_restart_idx", 64'(idx1), 64'd0);

        // Reset during O_WAIT
        found = 1'b0; n_wait = 0;
        while (!found && n_wait < 400) begin
            if (busy1 && ifc1.ann_state == 2'b10 && !ifc1.ann_start && !rv1) found = 1'b1;
            else begin step(1); n_wait++; end
        end
        check("t5_reach_o_wait", 64'(found), 64'd1);
        rst = 1'b1; step(1);
        check("t5_reset_outs", 64'({busy1, ifc1.ann_start, ifc1.ann_hidden, ifc1.ann_ld1, ifc1.ann_ld2,
                                    ifc1.ann_state, idx1, rv1, class1, ridx1, done1}), 64'd0);
`ifdef NN_SEQ_ACCURACY_EN
        check("t5_reset_correct_cnt", 64'(cc1), 64'd0);
`endif
        rst = 1'b0; step(1);

        // go while busy is ignored
        b_cap = cap1_cls.size(); b_done = cap1_done.size();
        go1 = 1'b1; step(1); go1 = 1'b0;
        step(10);
        check("t6_busy_mid", 64'(busy1), 64'd1);
        go1 = 1'b1; step(1); go1 = 1'b0;
        wait_idle1(400, "t6");
        check("t6_cap_count", 64'(cap1_cls.size() - b_cap), 64'd4);
        dsum = 0;
        for (int k = b_done; k < cap1_done.size(); k++) dsum += cap1_done[k];
        check("t6_done_count", 64'(dsum), 64'd1);
        check("t6_last_class", 64'(class1), 64'd5);
        check("t6_last_idx", 64'(ridx1), 64'd3);
        step(5);
        check("t6_no_second_batch", 64'(busy1), 64'd0);
`ifdef NN_SEQ_ACCURACY_EN
        check("t6_correct_cnt", 64'(cc1), 64'd3);
`endif

        // go together with abort in IDLE: abort wins
        go1 = 1'b1; abort1 = 1'b1; step(1); go1 = 1'b0; abort1 = 1'b0;
        check("t7_go_abort_idle", 64'(busy1), 64'd0);
        step(3);
        check("t7_still_idle", 64'({busy1, ifc1.ann_state}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
